win_detector: RTL and testbench

//   Sliding-window bit-stream detector: a parametrised, sequential successor to the
//   4-input single-output decoder exercises. Serial samples shift into a WIDTH-bit

---
 rtl/win_detector.sv | 130 +++++++++++++
 tb/tb_win_detector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/win_detector.sv
// ---------------------------------------------------------------------------
// win_detector
//   Sliding-window bit-stream detector. Serial samples shift into a WIDTH-bit
//   window (newest sample at bit 0, oldest at the MSB). Once the window holds
//   WIDTH samples, z asserts either on a threshold vote (popcount >= THRESH,
//   mode 0) or on an exact match against PATTERN (mode 1). Rising edges of z
//   on accepted samples are counted in a saturating counter.
//
// Ports
//   clk        in   1               system clock, rising edge
//   rst        in   1               asynchronous reset, active high
//   din_valid  in   1               sample strobe
//   din        in   1               serial sample
//   mode       in   1               0 = threshold vote, 1 = pattern match
//   clear      in   1               synchronous clear, active high
//   z          out  1               detection output, registered
//   full       out  1               window holds WIDTH valid samples
//   ones       out  $clog2(WIDTH+1) popcount of the current window
//   hits       out  CNT_W           saturating count of z rising edges
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ---------------------------------------------------------------------------
module win_detector #(
  parameter int               WIDTH   = 4,
  parameter int               THRESH  = 3,
  parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic                       din,
  input  logic                       mode,
  input  logic                       clear,
  output logic                       z,
  output logic                       full,
  output logic [$clog2(WIDTH+1)-1:0] ones,
  output logic [CNT_W-1:0]           hits
);

  localparam int OW = $clog2(WIDTH + 1);

  localparam logic [OW-1:0]    FILL_MAX = OW'(WIDTH);
  localparam logic [OW-1:0]    THRESH_W = OW'(THRESH);
  localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

  // State registers and their next-state values
  logic [WIDTH-1:0] win_q,  win_d;
  logic [OW-1:0]    fill_q, fill_d;
  logic             z_q,    z_d;
  logic             full_q, full_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic [CNT_W-1:0] hits_q, hits_d;

  // Window as it would look after accepting din this cycle
  logic [WIDTH-1:0] win_shift;
  logic [OW-1:0]    fill_inc;
  logic [OW-1:0]    pop_shift;
  logic             full_shift;
  logic             z_shift;

  assign win_shift  = {win_q[WIDTH-2:0], din};
  assign fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
  assign full_shift = (fill_inc == FILL_MAX);

  always_comb begin
    pop_shift = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_shift = pop_shift + OW'(win_shift[i]);
    end
  end

  // Detection is suppressed until the window has filled (warm-up).
  assign z_shift = full_shift &&
                   (mode ? (win_shift == PATTERN) : (pop_shift >= THRESH_W));

  // Next-state: clear beats a sample; with neither, everything holds.
  // mode only influences the result when a sample is accepted.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    z_d    = z_q;
    full_d = full_q;
    ones_d = ones_q;
    hits_d = hits_q;
    if (clear) begin
      win_d  = '0;
      fill_d = '0;
      z_d    = 1'b0;
      full_d = 1'b0;
      ones_d = '0;
      hits_d = '0;
    end else if (din_valid) begin
      win_d  = win_shift;
      fill_d = fill_inc;
      full_d = full_shift;
      ones_d = pop_shift;
      z_d    = z_shift;
      // Count only 0->1 transitions; a z that stays high counts once.
      if (z_shift && !z_q && (hits_q != HITS_MAX)) begin
        hits_d = hits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      full_q <= 1'b0;
      ones_q <= '0;
      hits_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      full_q <= full_d;
      ones_q <= ones_d;
      hits_q <= hits_d;
    end
  end

  assign z    = z_q;
  assign full = full_q;
  assign ones = ones_q;
  assign hits = hits_q;

endmodule

// File: tb/tb_win_detector.sv
// ---------------------------------------------------------------------------
// tb_win_detector
//   Drives two win_detector instances (default counter width and a 2-bit
//   counter) with the same stimulus: directed scenarios first, then a long
//   randomized run with occasional clears and asynchronous resets. Expected
//   values come from a sample-history model of the detection rules.
// ---------------------------------------------------------------------------
module tb_win_detector;

  localparam int               WIDTH   = 4;
  localparam int               THRESH  = 3;
  localparam logic [WIDTH-1:0] PATTERN = 4'b1011;
  localparam int               CNT_W   = 8;
  localparam int               CNT_WS  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic mode = 1'b0;
  logic clear = 1'b0;

  logic              z, full;
  logic [2:0]        ones;
  logic [CNT_W-1:0]  hits;
  logic              z_s, full_s;
  logic [2:0]        ones_s;
  logic [CNT_WS-1:0] hits_s;

  always #5 clk = ~clk;

  win_detector #(.WIDTH(WIDTH), .THRESH(THRESH), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .mode(mode), .clear(clear),
    .z(z), .full(full), .ones(ones), .hits(hits)
  );

  win_detector #(.WIDTH(WIDTH), .THRESH(THRESH), .PATTERN(PATTERN), .CNT_W(CNT_WS)) dut_s (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .mode(mode), .clear(clear),
    .z(z_s), .full(full_s), .ones(ones_s), .hits(hits_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the list of accepted samples since the last clear/reset
  // (only the most recent WIDTH are relevant), plus z and the hit counters.
  int hist[$];
  int m_z, m_full, m_ones, m_win, m_hits, m_hits_s;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_z = 0; m_full = 0; m_ones = 0; m_win = 0; m_hits = 0; m_hits_s = 0;
  endfunction

  function automatic void model_accept(input int d, input int md);
    int nz;
    hist.push_back(d);
    if (hist.size() > WIDTH) void'(hist.pop_front());
    m_win = 0;
    m_ones = 0;
    foreach (hist[i]) begin
      m_win  = m_win * 2 + hist[i];
      m_ones = m_ones + hist[i];
    end
    m_full = (hist.size() == WIDTH) ? 1 : 0;
    if (m_full == 0)      nz = 0;
    else if (md != 0)     nz = (m_win == int'(PATTERN)) ? 1 : 0;
    else                  nz = (m_ones >= THRESH) ? 1 : 0;
    if (nz == 1 && m_z == 0) begin
      if (m_hits   < (1 << CNT_W)  - 1) m_hits++;
      if (m_hits_s < (1 << CNT_WS) - 1) m_hits_s++;
    end
    m_z = nz;
  endfunction

  task automatic compare_all();
    check_val("z",      32'(z),      32'(m_z));
    check_val("full",   32'(full),   32'(m_full));
    check_val("ones",   32'(ones),   32'(m_ones));
    check_val("hits",   32'(hits),   32'(m_hits));
    check_val("z_s",    32'(z_s),    32'(m_z));
    check_val("full_s", 32'(full_s), 32'(m_full));
    check_val("ones_s", 32'(ones_s), 32'(m_ones));
    check_val("hits_s", 32'(hits_s), 32'(m_hits_s));
  endtask

  // One clock transaction: drive on the falling edge, update the model at the
  // rising edge, sample outputs 1 time unit later.
  task automatic step(input logic dv, input logic d, input logic md, input logic c);
    @(negedge clk);
    din_valid = dv; din = d; mode = md; clear = c;
    @(posedge clk);
    if (c)       model_reset();
    else if (dv) model_accept(int'(d), int'(md));
    #1;
    $display("t=%0t dv=%0d din=%0d mode=%0d clr=%0d -> z=%0d full=%0d ones=%0d hits=%0d hits_s=%0d",
             $time, dv, d, md, c, z, full, ones, hits, hits_s);
    compare_all();
  endtask

  // Reset pulse placed between clock edges; outputs must drop immediately.
  task automatic rst_pulse();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    $display("t=%0t async reset -> z=%0d full=%0d ones=%0d hits=%0d", $time, z, full, ones, hits);
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    compare_all();
    check_val("rst_z", 32'(z), 32'd0);
    #3;
    rst = 1'b0;

    // 1: warm-up
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    check_val("t1_z_warm", 32'(z), 32'd0);
    check_val("t1_full_warm", 32'(full), 32'd0);
    check_val("t1_ones_warm", 32'(ones), 32'd3);
    step(1, 1, 0, 0);
    check_val("t1_full", 32'(full), 32'd1);
    check_val("t1_ones", 32'(ones), 32'd4);
    check_val("t1_z", 32'(z), 32'd1);
    check_val("t1_hits", 32'(hits), 32'd1);

    // 2: threshold boundary (window 1111 -> 1110 -> 1100 -> 1001)
    step(1, 0, 0, 0);
    check_val("t2_ones_3", 32'(ones), 32'd3);
    check_val("t2_z_3", 32'(z), 32'd1);
    step(1, 0, 0, 0);
    check_val("t2_ones_2", 32'(ones), 32'd2);
    check_val("t2_z_2", 32'(z), 32'd0);
    step(1, 1, 0, 0);
    check_val("t2_z_1001", 32'(z), 32'd0);

    // 3: pattern mode
    step(1, 1, 1, 0); step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 1, 1, 0);
    check_val("t3_z_match", 32'(z), 32'd1);
    check_val("t3_hits", 32'(hits), 32'd2);
    step(1, 0, 1, 0);
    check_val("t3_z_0110", 32'(z), 32'd0);
    step(1, 1, 1, 0);   // 1101: three ones but no pattern match
    check_val("t3_z_1101", 32'(z), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0); // mode flips to vote, no sample accepted
      check_val("t3_z_flip_hold", 32'(z), 32'd0);
      check_val("t3_ones_hold", 32'(ones), 32'd3);
    end

    // 4: edge counting and saturation
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    check_val("t4_z", 32'(z), 32'd1);
    check_val("t4_hits", 32'(hits), 32'd3);
    for (int r = 0; r < 5; r++) begin
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
    end
    check_val("t4_hits_8", 32'(hits), 32'd8);
    check_val("t4_hits_sat", 32'(hits_s), 32'd3);
    step(0, 0, 0, 0);
    check_val("t4_hits_sat_hold", 32'(hits_s), 32'd3);

    // 5: clear wins over a simultaneous sample
    check_val("t5_pre_z", 32'(z), 32'd1);
    step(1, 1, 0, 1);
    check_val("t5_z", 32'(z), 32'd0);
    check_val("t5_full", 32'(full), 32'd0);
    check_val("t5_ones", 32'(ones), 32'd0);
    check_val("t5_hits", 32'(hits), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check_val("t5_full_refill", 32'(full), 32'd0);
    end

    // 6: async reset mid-stream
    rst_pulse();
    check_val("t6_z", 32'(z), 32'd0);
    check_val("t6_ones", 32'(ones), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check_val("t6_full_warm", 32'(full), 32'd0);
    end
    step(1, 1, 0, 0);
    check_val("t6_full", 32'(full), 32'd1);
    check_val("t6_z", 32'(z), 32'd1);
    check_val("t6_hits", 32'(hits), 32'd1);

    // Randomized run
    begin
      logic md;
      md = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 199) == 0) begin
          rst_pulse();
        end else begin
          if ($urandom_range(0, 15) == 0) md = ~md;
          step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), md,
               ($urandom_range(0, 59) == 0));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
